// File: rtl/arbitro_bus_memoria_ventanas.sv
// Read-port arbiter shared by two window fetch units (ventana 0 / ventana 1).
// Only the current bus owner can issue reads. Every read carries an owner
// tag down a pipeline that matches the memory latency, so data returning
// after a handover still reaches the window that asked for it.
//
// Handshake: a window raises req_vN with a stable dir_vN and holds both until
// acept_vN is high in the same cycle. That cycle consumes the request. The
// read is issued on the memory port in the next cycle, and the data comes
// back as a one-cycle valido_vN pulse with dato_vN. Neither dato_vN nor
// valido_vN has a ready/backpressure path.
module arbitro_bus_memoria_ventanas #(
  parameter int ANCHO_DIR    = 16,
  parameter int ANCHO_DATO   = 8,
  parameter int LATENCIA_MEM = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  habilitar_cambio,
  input  logic                  posicion,
  output logic                  cambio_pos,
  input  logic                  req_v0,
  input  logic                  req_v1,
  input  logic [ANCHO_DIR-1:0]  dir_v0,
  input  logic [ANCHO_DIR-1:0]  dir_v1,
  output logic                  acept_v0,
  output logic                  acept_v1,
  output logic [ANCHO_DATO-1:0] dato_v0,
  output logic [ANCHO_DATO-1:0] dato_v1,
  output logic                  valido_v0,
  output logic                  valido_v1,
  output logic                  dueno,
  output logic                  mem_rd_en,
  output logic [ANCHO_DIR-1:0]  mem_dir,
  input  logic [ANCHO_DATO-1:0] mem_dato
);

  // A handover request is outstanding until the control FSM performs the swap.
  logic pendiente;

  // Tag pipeline. Stage k holds the read issued k cycles after mem_rd_en.
  // Stage LATENCIA_MEM lines up with the cycle in which mem_dato is valid.
  logic [LATENCIA_MEM:0] tag_valido;
  logic [LATENCIA_MEM:0] tag_dueno;

  logic                 emitir;
  logic [ANCHO_DIR-1:0] dir_sel;
  logic                 req_dueno;
  logic                 req_otro;
  logic                 pedir_cambio;

  // Accept only the owner, and only outside the handover window and reset.
  assign acept_v0 = ~dueno & req_v0 & ~posicion & ~reset;
  assign acept_v1 =  dueno & req_v1 & ~posicion & ~reset;
  assign emitir   = acept_v0 | acept_v1;
  assign dir_sel  = dueno ? dir_v1 : dir_v0;

  // Ask for the bus only when the owner is idle. A busy owner keeps the bus.
  assign req_dueno    = dueno ? req_v1 : req_v0;
  assign req_otro     = dueno ? req_v0 : req_v1;
  assign pedir_cambio = req_otro & ~req_dueno & ~posicion & ~pendiente;

  // Ownership toggles only on the control FSM's handover strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      dueno <= 1'b0;
    end else if (habilitar_cambio) begin
      dueno <= ~dueno;
    end
  end

  // One request pulse per handover. The swap itself re-arms it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cambio_pos <= 1'b0;
      pendiente  <= 1'b0;
    end else begin
      cambio_pos <= pedir_cambio;
      if (habilitar_cambio) begin
        pendiente <= 1'b0;
      end else if (pedir_cambio) begin
        pendiente <= 1'b1;
      end
    end
  end

  // Register the accepted read onto the memory port. The address holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd_en <= 1'b0;
      mem_dir   <= '0;
    end else begin
      mem_rd_en <= emitir;
      if (emitir) begin
        mem_dir <= dir_sel;
      end
    end
  end

  // Shift owner tags alongside the memory latency. Reset drops reads in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valido <= '0;
      tag_dueno  <= '0;
    end else begin
      tag_valido[0] <= emitir;
      tag_dueno[0]  <= dueno;
      for (int i = 1; i <= LATENCIA_MEM; i++) begin
        tag_valido[i] <= tag_valido[i-1];
        tag_dueno[i]  <= tag_dueno[i-1];
      end
    end
  end

  // Route returning data to the window named by its tag. The other window holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      dato_v0   <= '0;
      dato_v1   <= '0;
      valido_v0 <= 1'b0;
      valido_v1 <= 1'b0;
    end else begin
      valido_v0 <= tag_valido[LATENCIA_MEM] & ~tag_dueno[LATENCIA_MEM];
      valido_v1 <= tag_valido[LATENCIA_MEM] &  tag_dueno[LATENCIA_MEM];
      if (tag_valido[LATENCIA_MEM] & ~tag_dueno[LATENCIA_MEM]) begin
        dato_v0 <= mem_dato;
      end
      if (tag_valido[LATENCIA_MEM] & tag_dueno[LATENCIA_MEM]) begin
        dato_v1 <= mem_dato;
      end
    end
  end

endmodule
